// File: rtl/input_cond_pkg.sv
// Shared constants for the button/switch input conditioner.
// DEBOUNCE_CYCLES_HW gives a 10 ms debounce window at 50 MHz.
package input_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int DEBOUNCE_CYCLES_HW      = 500000;
    localparam int SW_WIDTH_DEFAULT        = 8;

endpackage

// File: rtl/input_conditioner_debouncer.sv
// Two-flop synchronizer followed by a saturating-count debouncer.
// Out changes only after s2 has disagreed with it for DEBOUNCE_CYCLES edges.
module debouncer
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic In,
    output logic Out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= In;
            s2 <= s1;
            // Any agreement with the stable level restarts the window.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign Out = stable;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw board inputs: debounced buttons, a Run press strobe,
// and synchronized (not debounced) slide switches.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SW_WIDTH        = SW_WIDTH_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Reset_Load_Clear_In,
    input  logic                Run_In,
    input  logic [SW_WIDTH-1:0] SW_In,
    output logic                Reset_Load_Clear,
    output logic                Run,
    output logic                Run_Pulse,
    output logic [SW_WIDTH-1:0] SW
);

    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic                run_prev;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rlc_db (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Reset_Load_Clear_In),
        .Out   (Reset_Load_Clear)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Run_In),
        .Out   (Run)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            run_prev <= 1'b0;
        end else begin
            sw_s1    <= SW_In;
            sw_s2    <= sw_s1;
            run_prev <= Run;
        end
    end

    // Both terms are registered, so the strobe is clean for the cycle
    // in which the debounced Run level first reads high.
    assign Run_Pulse = Run & ~run_prev;
    assign SW        = sw_s2;

endmodule
